// File: rtl/bp_me_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 slave port among several WB masters.
// The grant is registered and held across a whole classic cycle or wrapped burst.
module bp_me_wb_arbiter #(
    parameter int unsigned num_masters_p  = 2,
    parameter int unsigned data_width_p   = 64,
    parameter int unsigned adr_width_p    = 37,
    localparam int unsigned sel_width_lp  = data_width_p / 8,
    localparam int unsigned id_width_lp   = (num_masters_p > 1) ? $clog2(num_masters_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,

    input  logic [num_masters_p*adr_width_p-1:0]   m_adr_i,
    input  logic [num_masters_p*data_width_p-1:0]  m_dat_i,
    input  logic [num_masters_p-1:0]               m_cyc_i,
    input  logic [num_masters_p-1:0]               m_stb_i,
    input  logic [num_masters_p*sel_width_lp-1:0]  m_sel_i,
    input  logic [num_masters_p-1:0]               m_we_i,
    input  logic [num_masters_p*3-1:0]             m_cti_i,
    input  logic [num_masters_p*2-1:0]             m_bte_i,
    output logic [data_width_p-1:0]                m_dat_o,
    output logic [num_masters_p-1:0]               m_ack_o,

    output logic [adr_width_p-1:0]                 s_adr_o,
    output logic [data_width_p-1:0]                s_dat_o,
    output logic                                   s_cyc_o,
    output logic                                   s_stb_o,
    output logic [sel_width_lp-1:0]                s_sel_o,
    output logic                                   s_we_o,
    output logic [2:0]                             s_cti_o,
    output logic [1:0]                             s_bte_o,
    input  logic [data_width_p-1:0]                s_dat_i,
    input  logic                                   s_ack_i,

    output logic [num_masters_p-1:0]               grant_o
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                   state_q, state_d;
    logic [id_width_lp-1:0]   grant_id_q, grant_id_d;
    logic [id_width_lp-1:0]   last_id_q, last_id_d;
    logic [num_masters_p-1:0] grant_q, grant_d;

    logic [adr_width_p-1:0]   adr_a [num_masters_p];
    logic [data_width_p-1:0]  dat_a [num_masters_p];
    logic [sel_width_lp-1:0]  sel_a [num_masters_p];
    logic [2:0]               cti_a [num_masters_p];
    logic [1:0]               bte_a [num_masters_p];

    for (genvar i = 0; i < num_masters_p; i++) begin : g_unpack
        assign adr_a[i] = m_adr_i[i*adr_width_p +: adr_width_p];
        assign dat_a[i] = m_dat_i[i*data_width_p +: data_width_p];
        assign sel_a[i] = m_sel_i[i*sel_width_lp +: sel_width_lp];
        assign cti_a[i] = m_cti_i[i*3 +: 3];
        assign bte_a[i] = m_bte_i[i*2 +: 2];
    end

    // First requester found scanning cyclically upward from the slot after last.
    function automatic logic [id_width_lp-1:0] rr_pick(
        input logic [num_masters_p-1:0] req,
        input logic [id_width_lp-1:0]   last
    );
        logic [id_width_lp-1:0] idx;
        logic [id_width_lp-1:0] pick;
        logic                   found;
        idx   = last;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < num_masters_p; k++) begin
            idx = (idx == id_width_lp'(num_masters_p - 1)) ? '0 : idx + id_width_lp'(1);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    logic                   busy;
    logic                   g_cyc;
    logic                   g_stb;
    logic                   g_we;
    logic [2:0]             g_cti;
    logic                   acc;
    logic                   end_xfer;
    logic [id_width_lp-1:0] pick_id;

    assign busy    = (state_q == StBusy);
    assign g_cyc   = m_cyc_i[grant_id_q];
    assign g_stb   = m_stb_i[grant_id_q];
    assign g_we    = m_we_i[grant_id_q];
    assign g_cti   = cti_a[grant_id_q];
    assign pick_id = rr_pick(m_cyc_i, last_id_q);

    always_comb begin
        s_cyc_o = busy & g_cyc;
        s_stb_o = busy & g_stb;
        s_we_o  = busy & g_we;
        s_adr_o = busy ? adr_a[grant_id_q] : '0;
        s_dat_o = busy ? dat_a[grant_id_q] : '0;
        s_sel_o = busy ? sel_a[grant_id_q] : '0;
        s_cti_o = busy ? g_cti : 3'b000;
        s_bte_o = busy ? bte_a[grant_id_q] : 2'b00;
    end

    // Only classic (000) and end-of-burst (111) beats close the transfer.
    assign acc      = s_ack_i & s_cyc_o & s_stb_o;
    assign end_xfer = acc & ((g_cti == 3'b000) || (g_cti == 3'b111));

    assign m_ack_o = grant_q & {num_masters_p{acc}};
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        grant_d    = grant_q;
        unique case (state_q)
            StIdle: begin
                if (|m_cyc_i) begin
                    state_d          = StBusy;
                    grant_id_d       = pick_id;
                    grant_d          = '0;
                    grant_d[pick_id] = 1'b1;
                end
            end
            StBusy: begin
                if (end_xfer || !g_cyc) begin
                    state_d   = StIdle;
                    last_id_d = grant_id_q;
                    grant_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            grant_id_q <= '0;
            last_id_q  <= id_width_lp'(num_masters_p - 1);
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            grant_q    <= grant_d;
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(grant_q));
    a_ack_needs_cyc: assert property (@(posedge clk_i) disable iff (reset_i)
        s_ack_i |-> s_cyc_o);
    a_no_burst_truncate: assert property (@(posedge clk_i) disable iff (reset_i)
        (busy && state_d == StBusy && s_cti_o == 3'b010 && !acc) |=> (s_cti_o != 3'b000));
`endif

endmodule

// File: tb/tb_bp_me_wb_arbiter.sv
// Scoreboard bench for bp_me_wb_arbiter with three masters and a zero-wait-state slave.
module tb_bp_me_wb_arbiter;

    localparam int unsigned NM = 3;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 37;
    localparam int unsigned SW = DW / 8;
    localparam logic [DW-1:0] SLV_DATA = 64'h0000_0000_DEAD_BEEF;

    logic clk;
    logic rst;

    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat;
    logic [NM-1:0]    m_cyc;
    logic [NM-1:0]    m_stb;
    logic [NM*SW-1:0] m_sel;
    logic [NM-1:0]    m_we;
    logic [NM*3-1:0]  m_cti;
    logic [NM*2-1:0]  m_bte;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack;
    logic [AW-1:0]    s_adr;
    logic [DW-1:0]    s_dat;
    logic             s_cyc;
    logic             s_stb;
    logic [SW-1:0]    s_sel;
    logic             s_we;
    logic [2:0]       s_cti;
    logic [1:0]       s_bte;
    logic [DW-1:0]    s_dat_i;
    logic             s_ack;
    logic [NM-1:0]    grant;

    // Zero-wait-state slave: acks every strobe of an open cycle.
    assign s_ack   = s_cyc & s_stb;
    assign s_dat_i = SLV_DATA;

    bp_me_wb_arbiter #(
        .num_masters_p(NM),
        .data_width_p (DW),
        .adr_width_p  (AW)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_sel_i (m_sel),
        .m_we_i  (m_we),
        .m_cti_i (m_cti),
        .m_bte_i (m_bte),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack),
        .s_adr_o (s_adr),
        .s_dat_o (s_dat),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_sel_o (s_sel),
        .s_we_o  (s_we),
        .s_cti_o (s_cti),
        .s_bte_o (s_bte),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack),
        .grant_o (grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0]    mid;
        logic          gap;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic          we;
        logic [2:0]    cti;
        logic [1:0]    bte;
        logic [SW-1:0] sel;
    } beat_t;

    beat_t stim_q[$];
    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int mid, input logic [AW-1:0] adr, input logic we,
                                 input logic [2:0] cti, input logic [1:0] bte);
        beat_t b;
        b.mid = 2'(mid);
        b.gap = 1'b0;
        b.adr = adr;
        b.dat = {8'hC0, 8'(mid), 16'h0000, adr[31:0]};
        b.we  = we;
        b.cti = cti;
        b.bte = bte;
        b.sel = 8'hFF ^ 8'(mid);
        return b;
    endfunction

    // Master models: each drives the head of its own entries; an ack pops it.
    initial begin : drivers
        logic [NM-1:0] acked;
        int            h;
        m_adr = '0; m_dat = '0; m_cyc = '0; m_stb = '0;
        m_sel = '0; m_we = '0; m_cti = '0; m_bte = '0;
        forever begin
            @(negedge clk);
            acked = m_ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < NM; i++) begin
                if (acked[i]) begin
                    for (int j = 0; j < stim_q.size(); j++) begin
                        if (stim_q[j].mid == 2'(i)) begin
                            stim_q.delete(j);
                            break;
                        end
                    end
                end
            end
            for (int i = 0; i < NM; i++) begin
                h = -1;
                for (int j = 0; j < stim_q.size(); j++)
                    if (h < 0 && stim_q[j].mid == 2'(i)) h = j;
                m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
                m_adr[i*AW +: AW] = '0; m_dat[i*DW +: DW] = '0; m_sel[i*SW +: SW] = '0;
                m_cti[i*3 +: 3] = '0; m_bte[i*2 +: 2] = '0;
                if (h >= 0) begin
                    if (stim_q[h].gap) begin
                        stim_q.delete(h);
                    end else begin
                        m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_we[i] = stim_q[h].we;
                        m_adr[i*AW +: AW] = stim_q[h].adr;
                        m_dat[i*DW +: DW] = stim_q[h].dat;
                        m_sel[i*SW +: SW] = stim_q[h].sel;
                        m_cti[i*3 +: 3]   = stim_q[h].cti;
                        m_bte[i*2 +: 2]   = stim_q[h].bte;
                    end
                end
            end
        end
    end

    // Monitor: every accepted slave beat must match the next expected entry.
    initial begin : monitor
        beat_t e;
        logic  chk_rel;
        chk_rel = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk_rel = 1'b0;
                continue;
            end
            if (chk_rel) begin
                check("release_grant_zero", 64'(grant), 64'h0);
                chk_rel = 1'b0;
            end
            if (grant == '0 && m_cyc != '0)
                check("idle_slave_quiet", 64'({s_cyc, s_stb, s_we, |s_adr, |s_dat, |s_sel,
                                               |s_cti, |s_bte}), 64'h0);
            if (s_cyc && s_stb && s_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected: got grant %0b adr %0h expected no beat",
                             grant, s_adr);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_grant", 64'(grant), 64'(NM'(1) << e.mid));
                    check("beat_ack",   64'(m_ack), 64'(NM'(1) << e.mid));
                    check("beat_adr",   64'(s_adr), 64'(e.adr));
                    check("beat_wdat",  s_dat, e.dat);
                    check("beat_we",    64'(s_we), 64'(e.we));
                    check("beat_sel",   64'(s_sel), 64'(e.sel));
                    check("beat_cti",   64'(s_cti), 64'(e.cti));
                    check("beat_bte",   64'(s_bte), 64'(e.bte));
                    check("beat_rdat",  m_dat_o, SLV_DATA);
                    if (e.cti == 3'b000 || e.cti == 3'b111) chk_rel = 1'b1;
                end
            end
        end
    end

    task automatic both(input beat_t b);
        stim_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_drain();
        int n;
        for (n = 0; n < 300 && (stim_q.size() != 0 || exp_q.size() != 0 || grant != '0); n++)
            @(negedge clk);
        check("drain_exp_left", 64'(exp_q.size()), 64'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_grant(input logic [NM-1:0] mask);
        int n;
        for (n = 0; n < 50 && grant != mask; n++) @(negedge clk);
        check("wait_grant", 64'(grant), 64'(mask));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        stim_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stimulus
        beat_t b;
        int    n;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_s_cyc", 64'(s_cyc), 64'h0);
        check("rst_s_stb", 64'(s_stb), 64'h0);
        check("rst_m_ack", 64'(m_ack), 64'h0);
        check("rst_s_adr", 64'(s_adr), 64'h0);
        rst = 1'b0;

        // Single classic write from m0: one arbitration cycle before s_cyc.
        @(negedge clk);
        both(mk(0, 37'h10, 1'b1, 3'b000, 2'b00));
        for (n = 0; n < 10 && !m_cyc[0]; n++) @(negedge clk);
        check("lat_req_seen", 64'(m_cyc[0]), 64'h1);
        check("lat_idle_cyc", 64'(s_cyc), 64'h0);
        @(negedge clk);
        check("lat_busy_cyc", 64'(s_cyc), 64'h1);
        check("lat_grant", 64'(grant), 64'h1);
        wait_drain();

        // Contention right after reset: 0,1,0,1.
        do_reset();
        stim_q.push_back(mk(0, 37'h100, 1'b0, 3'b000, 2'b00));
        stim_q.push_back(mk(1, 37'h110, 1'b1, 3'b000, 2'b00));
        stim_q.push_back(mk(0, 37'h101, 1'b0, 3'b000, 2'b00));
        stim_q.push_back(mk(1, 37'h111, 1'b1, 3'b000, 2'b00));
        exp_q.push_back(mk(0, 37'h100, 1'b0, 3'b000, 2'b00));
        exp_q.push_back(mk(1, 37'h110, 1'b1, 3'b000, 2'b00));
        exp_q.push_back(mk(0, 37'h101, 1'b0, 3'b000, 2'b00));
        exp_q.push_back(mk(1, 37'h111, 1'b1, 3'b000, 2'b00));
        wait_drain();

        // 8-beat wrapped burst from m1; m0 requests mid-burst and must wait.
        for (int k = 0; k < 8; k++)
            both(mk(1, 37'(64 + ((4 + k) % 8)), 1'b1, (k == 7) ? 3'b111 : 3'b010, 2'b10));
        wait_grant(3'b010);
        both(mk(0, 37'h200, 1'b0, 3'b000, 2'b00));
        wait_drain();

        // Abort: m0 drops cyc after 2 of 4 beats, then m1 is served.
        both(mk(0, 37'h20, 1'b1, 3'b010, 2'b00));
        both(mk(0, 37'h21, 1'b1, 3'b010, 2'b00));
        b = mk(0, 37'h0, 1'b0, 3'b000, 2'b00);
        b.gap = 1'b1;
        stim_q.push_back(b);
        wait_grant(3'b001);
        both(mk(1, 37'h30, 1'b1, 3'b000, 2'b00));
        for (n = 0; n < 20 && m_cyc[0]; n++) @(negedge clk);
        check("abort_cyc_dropped", 64'(m_cyc[0]), 64'h0);
        check("abort_s_cyc", 64'(s_cyc), 64'h0);
        @(negedge clk);
        check("abort_idle", 64'(grant), 64'h0);
        @(negedge clk);
        check("abort_m1_grant", 64'(grant), 64'h2);
        wait_drain();

        // Asynchronous reset in the middle of an m0 burst.
        for (int k = 0; k < 4; k++) begin
            b = mk(0, 37'(80 + k), 1'b1, (k == 3) ? 3'b111 : 3'b010, 2'b00);
            stim_q.push_back(b);
            if (k == 0) exp_q.push_back(b);
        end
        for (n = 0; n < 20 && !m_ack[0]; n++) @(negedge clk);
        check("rstb_first_ack", 64'(m_ack[0]), 64'h1);
        #1;
        stim_q.delete();
        rst = 1'b1;
        #1;
        check("rstb_s_cyc", 64'(s_cyc), 64'h0);
        check("rstb_m_ack", 64'(m_ack), 64'h0);
        check("rstb_grant", 64'(grant), 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // All three request continuously with classic reads: 0,1,2,0.
        stim_q.push_back(mk(0, 37'h60, 1'b0, 3'b000, 2'b00));
        stim_q.push_back(mk(0, 37'h63, 1'b0, 3'b000, 2'b00));
        stim_q.push_back(mk(1, 37'h61, 1'b0, 3'b000, 2'b00));
        stim_q.push_back(mk(2, 37'h62, 1'b0, 3'b000, 2'b00));
        exp_q.push_back(mk(0, 37'h60, 1'b0, 3'b000, 2'b00));
        exp_q.push_back(mk(1, 37'h61, 1'b0, 3'b000, 2'b00));
        exp_q.push_back(mk(2, 37'h62, 1'b0, 3'b000, 2'b00));
        exp_q.push_back(mk(0, 37'h63, 1'b0, 3'b000, 2'b00));
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
